scan_mux: RTL and testbench
===========================

Name: scan_mux

Overview:
- Parametrised successor to the team's 16:1 decoder-plus-mux tree.
- N-channel, W-bit selector with a registered output.
- Two modes: manual select, or auto-scan that rotates through enabled channels with a programmable dwell time.
- Sits in front of shared downstream logic (display, serialiser, comparator) that samples one channel at a time.

Parameters:
- WIDTH, 8, bit width of each channel.
- CHANNELS, 16, number of input channels (>=2; need not be a power of 2).
- DWELL, 4, clock cycles spent on each channel in scan mode (>=1).
- SEL_W (localparam), $clog2(CHANNELS), width of channel index.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in  input  CHANNELS*WIDTH  packed channel data; channel i = in[WIDTH*(i+1)-1 : WIDTH*i].
- sel  input  SEL_W  channel index: used directly in manual mode; load value in scan mode.
- mode  input  1  0 = manual, 1 = auto-scan.
- load  input  1  scan mode only: one-cycle pulse, jump to sel.
- en_mask  input  CHANNELS  per-channel enable; disabled channels are skipped or blanked.
- w  output  WIDTH  registered selected data.
- cur_ch  output  SEL_W  registered index of channel currently driving w.
- valid  output  1  registered: w holds data from an enabled, in-range channel.
- wrap  output  1  one-cycle pulse when scan index wraps.

Behaviour:
- Reset (async, rst=1): w=0, cur_ch=0, valid=0, wrap=0, dwell counter=0. Outputs change immediately; the first update happens on the first clk edge after rst deasserts.
- Each rising edge computes next_ch, then registers together:
  - cur_ch <= next_ch
  - w <= in slice of next_ch
  - valid <= en_mask[next_ch]
  - w, cur_ch and valid are therefore always mutually consistent. Latency from in/sel to w is 1 cycle.
- Blanking: if next_ch >= CHANNELS or en_mask[next_ch]=0, then w <= 0 and valid <= 0.
- Manual mode (mode=0):
  - next_ch = sel.
  - Dwell counter held at 0; wrap=0; load ignored.
  - Out-of-range sel is still registered into cur_ch, with blanking applied.
- Scan mode (mode=1), priority from highest:
  1. load=1: if sel < CHANNELS, next_ch = sel and dwell=0. If sel is out of range, load is ignored and the normal scan rules below apply.
  2. All en_mask bits 0: next_ch = cur_ch; dwell counter keeps counting; wrap=0; output blanked.
  3. dwell == DWELL-1: next_ch = lowest enabled index > cur_ch; if none exists, lowest enabled index overall. dwell <= 0.
  4. Otherwise: next_ch = cur_ch; dwell <= dwell+1.
- Data is live: w re-samples the in slice of cur_ch every cycle during the dwell, not just on entry.
- wrap:
  - Registered; high for exactly one cycle on the edge where a case-3 advance selects an index <= the previous cur_ch.
  - With a single enabled channel, wrap pulses on every dwell expiry.
  - load never raises wrap.
- Mode switch:
  - manual->scan: scan resumes from current cur_ch with dwell=0.
  - scan->manual: sel takes effect on the same edge; dwell cleared.
- DWELL=1: advances every cycle.
- en_mask changes are honoured on the next edge. If cur_ch becomes disabled mid-dwell, it is blanked until expiry; no early advance.
- Reset mid-scan returns to channel 0 with dwell 0, regardless of en_mask.

Optional Feature:
- Macro: SCAN_MUX_PARITY_EN.
- Defined: adds output port w_par (1 bit), registered on the same edge as w, equal to even parity ^(next w value). Reset value 0; 0 when blanked.
- Undefined: port w_par and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset: assert rst mid-operation with cur_ch=5 -> w=0, cur_ch=0, valid=0, wrap=0 immediately without a clock edge; first edge after release (manual, sel=3) -> cur_ch=3.
- Manual select: CHANNELS=16, WIDTH=8, channel i driven with 8'h10+i, en_mask=16'hFFFF, sel=0..15 -> one cycle later w=8'h10+sel, valid=1; en_mask[7]=0 with sel=7 -> w=0, valid=0.
- Scan with mask: DWELL=4, en_mask=16'h8421, mode=1 from cur_ch=0 -> channels 0,5,10,15,0 each held 4 cycles; wrap pulses once, on the 15->0 edge only.
- Load priority: scan on ch 5 at dwell=2, pulse load with sel=12 -> next edge cur_ch=12, dwell restarts (ch 12 held 4 full cycles), wrap=0; load with sel=12 while en_mask[12]=0 -> cur_ch=12, valid=0.
- Degenerate masks: en_mask=0 in scan -> cur_ch frozen, valid=0, wrap never asserts; en_mask=16'h0040 -> cur_ch=6 steady, wrap every 4 cycles.
- Parity (SCAN_MUX_PARITY_EN defined): w=8'h13 -> w_par=1; w=8'h11 -> w_par=0; blanked -> w_par=0.

Source files
------------

// File: rtl/scan_mux.sv
// scan_mux: N-channel, WIDTH-bit selector with registered output; manual select or auto-scan.
// Define SCAN_MUX_PARITY_EN to add the registered even-parity output w_par.
module scan_mux #(
    parameter int WIDTH     = 8,
    parameter int CHANNELS  = 16,
    parameter int DWELL     = 4,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] in,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      mode,
    input  logic                      load,
    input  logic [CHANNELS-1:0]       en_mask,
    output logic [WIDTH-1:0]          w,
    output logic [SEL_W-1:0]          cur_ch,
    output logic                      valid,
`ifdef SCAN_MUX_PARITY_EN
    output logic                      w_par,
`endif
    output logic                      wrap
);

    localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW_W-1:0] LAST = DW_W'(DWELL - 1);
    localparam logic [SEL_W:0] CH_LIM = (SEL_W + 1)'(CHANNELS);

    function automatic logic in_range(input logic [SEL_W-1:0] c);
        return {1'b0, c} < CH_LIM;
    endfunction

    logic [WIDTH-1:0] ch_data [CHANNELS];
    logic [DW_W-1:0]  dwell, next_dwell;
    logic [SEL_W-1:0] next_ch;
    logic             next_wrap;
    logic             next_valid;
    logic [WIDTH-1:0] next_w;
    logic             up_found, lo_found;
    logic [SEL_W-1:0] up_ch, lo_ch;

    always_comb begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            ch_data[i] = in[WIDTH*i +: WIDTH];
        end
    end

    // Lowest enabled channel above cur_ch, and lowest enabled channel overall.
    always_comb begin
        up_found = 1'b0;
        up_ch    = '0;
        lo_found = 1'b0;
        lo_ch    = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (en_mask[i] && !lo_found) begin
                lo_found = 1'b1;
                lo_ch    = SEL_W'(i);
            end
            if (en_mask[i] && !up_found && (SEL_W'(i) > cur_ch)) begin
                up_found = 1'b1;
                up_ch    = SEL_W'(i);
            end
        end
    end

    always_comb begin
        next_ch    = cur_ch;
        next_dwell = '0;
        next_wrap  = 1'b0;
        if (!mode) begin
            next_ch = sel;
        end else if (load && in_range(sel)) begin
            next_ch = sel;
        end else if (!lo_found) begin
            next_dwell = (dwell == LAST) ? '0 : dwell + 1'b1;
        end else if (dwell == LAST) begin
            // No enabled channel above cur_ch means the rotation restarts from the bottom.
            next_ch   = up_found ? up_ch : lo_ch;
            next_wrap = !up_found;
        end else begin
            next_dwell = dwell + 1'b1;
        end
    end

    always_comb begin
        next_valid = in_range(next_ch) && en_mask[next_ch];
        next_w     = next_valid ? ch_data[next_ch] : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w      <= '0;
            cur_ch <= '0;
            valid  <= 1'b0;
            wrap   <= 1'b0;
            dwell  <= '0;
        end else begin
            w      <= next_w;
            cur_ch <= next_ch;
            valid  <= next_valid;
            wrap   <= next_wrap;
            dwell  <= next_dwell;
        end
    end

`ifdef SCAN_MUX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_par <= 1'b0;
        end else begin
            w_par <= ^next_w;
        end
    end
`endif

endmodule

// File: tb/tb_scan_mux.sv
// Self-checking bench for scan_mux (16 channels x 8 bits, dwell 4) using an expectation queue.
module tb_scan_mux;

    typedef struct packed {
        logic [7:0] w;
        logic [3:0] ch;
        logic       v;
        logic       wr;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] in_bus;
    logic [3:0]   sel;
    logic         mode;
    logic         load;
    logic [15:0]  en_mask;
    logic [7:0]   w;
    logic [3:0]   cur_ch;
    logic         valid;
    logic         wrap;
`ifdef SCAN_MUX_PARITY_EN
    logic         w_par;
`endif

    exp_t q[$];
    exp_t e;
    exp_t got;
    int   checks = 0;
    int   failures = 0;

    scan_mux #(.WIDTH(8), .CHANNELS(16), .DWELL(4)) dut (
        .clk(clk),
        .rst(rst),
        .in(in_bus),
        .sel(sel),
        .mode(mode),
        .load(load),
        .en_mask(en_mask),
        .w(w),
        .cur_ch(cur_ch),
        .valid(valid),
`ifdef SCAN_MUX_PARITY_EN
        .w_par(w_par),
`endif
        .wrap(wrap)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; mode = 1'b0; sel = 4'd5; load = 1'b0; en_mask = '1;
        step();
        rst = 1'b0;
        q.push_back({8'h15, 4'd5, 1'b1, 1'b0});
        step();
        e = q.pop_front(); got = {w, cur_ch, valid, wrap}; checks++;
        if (got !== e) begin failures++; $display("FAIL pre_reset: got %h expected %h", got, e); end
        #3 rst = 1'b1;
        q.push_back({8'h00, 4'd0, 1'b0, 1'b0});
        #1;
        e = q.pop_front(); got = {w, cur_ch, valid, wrap}; checks++;
        if (got !== e) begin failures++; $display("FAIL async_reset: got %h expected %h", got, e); end
        sel = 4'd3;
        #2 rst = 1'b0;
        q.push_back({8'h13, 4'd3, 1'b1, 1'b0});
        step();
        e = q.pop_front(); got = {w, cur_ch, valid, wrap}; checks++;
        if (got !== e) begin failures++; $display("FAIL reset_release: got %h expected %h", got, e); end
    endtask

    task automatic test_manual;
        for (int s = 0; s < 16; s++) begin
            sel = 4'(s);
            q.push_back({8'(8'h10 + s), 4'(s), 1'b1, 1'b0});
            step();
            e = q.pop_front(); got = {w, cur_ch, valid, wrap}; checks++;
            if (got !== e) begin failures++; $display("FAIL manual_sel%0d: got %h expected %h", s, got, e); end
        end
        en_mask[7] = 1'b0; sel = 4'd7;
        q.push_back({8'h00, 4'd7, 1'b0, 1'b0});
        step();
        e = q.pop_front(); got = {w, cur_ch, valid, wrap}; checks++;
        if (got !== e) begin failures++; $display("FAIL manual_blank: got %h expected %h", got, e); end
        en_mask = '1;
    endtask

    task automatic test_scan_mask;
        logic [3:0] seq [6];
        logic [3:0] c;
        seq = '{4'd0, 4'd5, 4'd10, 4'd15, 4'd0, 4'd5};
        sel = 4'd0;
        step();
        mode = 1'b1; en_mask = 16'h8421;
        for (int k = 1; k <= 20; k++) begin
            c = seq[k / 4];
            q.push_back({8'h10 + 8'(c), c, 1'b1, (k == 16)});
            step();
            e = q.pop_front(); got = {w, cur_ch, valid, wrap}; checks++;
            if (got !== e) begin failures++; $display("FAIL scan_mask_k%0d: got %h expected %h", k, got, e); end
        end
    endtask

    task automatic test_load;
        for (int k = 0; k < 7; k++) begin
            if (k == 2) begin
                en_mask = '1; load = 1'b1; sel = 4'd12;
            end
            if (k < 2)       q.push_back({8'h15, 4'd5, 1'b1, 1'b0});
            else if (k < 6)  q.push_back({8'h1C, 4'd12, 1'b1, 1'b0});
            else             q.push_back({8'h1D, 4'd13, 1'b1, 1'b0});
            step();
            load = 1'b0;
            e = q.pop_front(); got = {w, cur_ch, valid, wrap}; checks++;
            if (got !== e) begin failures++; $display("FAIL load_k%0d: got %h expected %h", k, got, e); end
        end
        en_mask = 16'hEFFF; load = 1'b1; sel = 4'd12;
        q.push_back({8'h00, 4'd12, 1'b0, 1'b0});
        step();
        load = 1'b0;
        e = q.pop_front(); got = {w, cur_ch, valid, wrap}; checks++;
        if (got !== e) begin failures++; $display("FAIL load_disabled: got %h expected %h", got, e); end
    endtask

    task automatic test_degenerate;
        en_mask = '0;
        for (int k = 0; k < 8; k++) begin
            q.push_back({8'h00, 4'd12, 1'b0, 1'b0});
            step();
            e = q.pop_front(); got = {w, cur_ch, valid, wrap}; checks++;
            if (got !== e) begin failures++; $display("FAIL mask_zero_k%0d: got %h expected %h", k, got, e); end
        end
        en_mask = 16'h0040;
        for (int k = 1; k <= 16; k++) begin
            if (k < 4) q.push_back({8'h00, 4'd12, 1'b0, 1'b0});
            else       q.push_back({8'h16, 4'd6, 1'b1, (k % 4 == 0)});
            step();
            e = q.pop_front(); got = {w, cur_ch, valid, wrap}; checks++;
            if (got !== e) begin failures++; $display("FAIL single_ch_k%0d: got %h expected %h", k, got, e); end
        end
    endtask

    task automatic test_back_to_back;
        mode = 1'b0; sel = 4'd9; en_mask = '1;
        q.push_back({8'h19, 4'd9, 1'b1, 1'b0});
        step();
        e = q.pop_front(); got = {w, cur_ch, valid, wrap}; checks++;
        if (got !== e) begin failures++; $display("FAIL to_manual: got %h expected %h", got, e); end
        mode = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            if (k == 2) in_bus[9*8 +: 8] = 8'h5A;
            if (k == 4) in_bus[9*8 +: 8] = 8'h19;
            if (k == 1)      q.push_back({8'h19, 4'd9, 1'b1, 1'b0});
            else if (k < 4)  q.push_back({8'h5A, 4'd9, 1'b1, 1'b0});
            else             q.push_back({8'h1A, 4'd10, 1'b1, 1'b0});
            step();
            e = q.pop_front(); got = {w, cur_ch, valid, wrap}; checks++;
            if (got !== e) begin failures++; $display("FAIL live_scan_k%0d: got %h expected %h", k, got, e); end
        end
        mode = 1'b0; sel = 4'd2;
        q.push_back({8'h12, 4'd2, 1'b1, 1'b0});
        step();
        e = q.pop_front(); got = {w, cur_ch, valid, wrap}; checks++;
        if (got !== e) begin failures++; $display("FAIL mid_dwell_manual: got %h expected %h", got, e); end
        mode = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            if (k < 4) q.push_back({8'h12, 4'd2, 1'b1, 1'b0});
            else       q.push_back({8'h13, 4'd3, 1'b1, 1'b0});
            step();
            e = q.pop_front(); got = {w, cur_ch, valid, wrap}; checks++;
            if (got !== e) begin failures++; $display("FAIL resume_scan_k%0d: got %h expected %h", k, got, e); end
        end
    endtask

`ifdef SCAN_MUX_PARITY_EN
    task automatic test_parity;
        logic pq[$];
        logic pe;
        mode = 1'b0; en_mask = '1;
        for (int k = 0; k < 3; k++) begin
            case (k)
                0: begin sel = 4'd3; pq.push_back(1'b1); end
                1: begin sel = 4'd1; pq.push_back(1'b0); end
                default: begin sel = 4'd3; en_mask[3] = 1'b0; pq.push_back(1'b0); end
            endcase
            step();
            pe = pq.pop_front(); checks++;
            if (w_par !== pe) begin failures++; $display("FAIL parity_k%0d: got %b expected %b", k, w_par, pe); end
        end
        en_mask = '1;
    endtask
`endif

    initial begin
        for (int i = 0; i < 16; i++) in_bus[8*i +: 8] = 8'(8'h10 + i);
        test_reset();
        test_manual();
        test_scan_mask();
        test_load();
        test_degenerate();
        test_back_to_back();
`ifdef SCAN_MUX_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
